// File: rtl/demux1to3_buf_if.sv
// rtl/demux1to3_buf_if.sv - producer and three consumer handshake bundle for demux1to3_buf
interface demux1to3_buf_if #(
    parameter int width  = 32,
    parameter int bwidth = 12
);
    logic [width-1:0]  din;
    logic [1:0]        s;
    logic              din_valid;
    logic              din_ready;

    logic [width-1:0]  douta;
    logic              douta_valid;
    logic              douta_ready;

    logic [bwidth-1:0] doutb;
    logic              doutb_valid;
    logic              doutb_ready;

    logic [width-1:0]  doutc;
    logic              doutc_valid;
    logic              doutc_ready;

    // Producer and consumers side (drives data/select/readies, observes outputs)
    modport master (
        output din, s, din_valid,
        input  din_ready,
        input  douta, douta_valid,
        output douta_ready,
        input  doutb, doutb_valid,
        output doutb_ready,
        input  doutc, doutc_valid,
        output doutc_ready
    );

    // Distributor side
    modport slave (
        input  din, s, din_valid,
        output din_ready,
        output douta, douta_valid,
        input  douta_ready,
        output doutb, doutb_valid,
        input  doutb_ready,
        output doutc, doutc_valid,
        input  doutc_ready
    );
endinterface

// File: rtl/demux1to3_buf.sv
// rtl/demux1to3_buf.sv - 1-to-3 result distributor with one-entry buffer per output; DEMUX1TO3_STATS_EN adds accept counters
module demux1to3_buf #(
    parameter int width  = 32,
    parameter int bwidth = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    demux1to3_buf_if.slave bus
`ifdef DEMUX1TO3_STATS_EN
    ,
    output logic [7:0]     cnt_a,
    output logic [7:0]     cnt_b,
    output logic [7:0]     cnt_c,
    output logic           err_sel00
`endif
);

    logic              sel_a;
    logic              sel_b;
    logic              sel_c;
    logic              ready_int;
    logic              acc_a;
    logic              acc_b;
    logic              acc_c;

    logic [width-1:0]  data_a;
    logic [bwidth-1:0] data_b;
    logic [width-1:0]  data_c;
    logic              valid_a;
    logic              valid_b;
    logic              valid_c;

    // Decode the destination; 00 falls back to channel A like the operand mux
    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        sel_c = 1'b0;
        case (bus.s)
            2'b10:   sel_b = 1'b1;
            2'b11:   sel_c = 1'b1;
            default: sel_a = 1'b1;
        endcase
    end

    // Ready when the selected buffer is empty or is being drained this cycle
    always_comb begin
        ready_int = 1'b0;
        if (sel_a)
            ready_int = !valid_a || bus.douta_ready;
        else if (sel_b)
            ready_int = !valid_b || bus.doutb_ready;
        else if (sel_c)
            ready_int = !valid_c || bus.doutc_ready;
    end

    assign acc_a = bus.din_valid && ready_int && sel_a;
    assign acc_b = bus.din_valid && ready_int && sel_b;
    assign acc_c = bus.din_valid && ready_int && sel_c;

    // Channel A buffer: refill wins over drain so back-to-back words leave no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a  <= '0;
            valid_a <= 1'b0;
        end else if (acc_a) begin
            data_a  <= bus.din;
            valid_a <= 1'b1;
        end else if (valid_a && bus.douta_ready) begin
            valid_a <= 1'b0;
        end
    end

    // Channel B buffer: carries only the low bwidth bits of the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_b  <= '0;
            valid_b <= 1'b0;
        end else if (acc_b) begin
            data_b  <= bus.din[bwidth-1:0];
            valid_b <= 1'b1;
        end else if (valid_b && bus.doutb_ready) begin
            valid_b <= 1'b0;
        end
    end

    // Channel C buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_c  <= '0;
            valid_c <= 1'b0;
        end else if (acc_c) begin
            data_c  <= bus.din;
            valid_c <= 1'b1;
        end else if (valid_c && bus.doutc_ready) begin
            valid_c <= 1'b0;
        end
    end

    assign bus.din_ready   = ready_int;
    assign bus.douta       = data_a;
    assign bus.douta_valid = valid_a;
    assign bus.doutb       = data_b;
    assign bus.doutb_valid = valid_b;
    assign bus.doutc       = data_c;
    assign bus.doutc_valid = valid_c;

`ifdef DEMUX1TO3_STATS_EN
    // Per-channel accept counters (free-running wrap) and sticky flag for the default select code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a     <= 8'd0;
            cnt_b     <= 8'd0;
            cnt_c     <= 8'd0;
            err_sel00 <= 1'b0;
        end else begin
            if (acc_a)
                cnt_a <= cnt_a + 8'd1;
            if (acc_b)
                cnt_b <= cnt_b + 8'd1;
            if (acc_c)
                cnt_c <= cnt_c + 8'd1;
            if (acc_a && (bus.s == 2'b00))
                err_sel00 <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux1to3_buf.sv
// tb/tb_demux1to3_buf.sv - directed vector bench for demux1to3_buf
module tb_demux1to3_buf;

    logic clk;
    logic rst_n;

    demux1to3_buf_if #(.width(32), .bwidth(12)) bus ();

`ifdef DEMUX1TO3_STATS_EN
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [7:0] cnt_c;
    logic       err_sel00;
`endif

    demux1to3_buf #(.width(32), .bwidth(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef DEMUX1TO3_STATS_EN
        ,
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .cnt_c     (cnt_c),
        .err_sel00 (err_sel00)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [1:0]  s;
        logic        v;
        logic        ra;
        logic        rb;
        logic        rc;
        logic        rdy;
        logic        va;
        logic [31:0] a;
        logic        vb;
        logic [11:0] b;
        logic        vc;
        logic [31:0] c;
    } vec_t;

    vec_t vecs [9];
    int   nvec;
    int   nerr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [1:0] sel, input logic v,
                         input logic ra, input logic rb, input logic rc);
        bus.din         = d;
        bus.s           = sel;
        bus.din_valid   = v;
        bus.douta_ready = ra;
        bus.doutb_ready = rb;
        bus.doutc_ready = rc;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;

        //            din           s      v     ra    rb    rc    rdy   va    a             vb    b        vc    c
        vecs[0] = '{32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 12'hEEF, 1'b0, 32'h0};
        vecs[1] = '{32'h00000055, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55,       1'b1, 12'hEEF, 1'b0, 32'h0};
        vecs[2] = '{32'h11111111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55,       1'b1, 12'hEEF, 1'b1, 32'h11111111};
        vecs[3] = '{32'h22222222, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55,       1'b1, 12'hEEF, 1'b1, 32'h11111111};
        vecs[4] = '{32'h22222222, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h55,       1'b1, 12'hEEF, 1'b1, 32'h22222222};
        vecs[5] = '{32'h00001234, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1234,     1'b1, 12'hEEF, 1'b1, 32'h22222222};
        vecs[6] = '{32'h00000000, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234,     1'b0, 12'hEEF, 1'b1, 32'h22222222};
        vecs[7] = '{32'hABCDE123, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234,     1'b1, 12'h123, 1'b0, 32'h22222222};
        vecs[8] = '{32'h00000000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234,     1'b1, 12'h123, 1'b0, 32'h22222222};

        // Reset state
        drive(32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_din_ready", {31'd0, bus.din_ready}, 32'd1);
        chk("rst_va", {31'd0, bus.douta_valid}, 32'd0);
        chk("rst_vb", {31'd0, bus.doutb_valid}, 32'd0);
        chk("rst_vc", {31'd0, bus.doutc_valid}, 32'd0);
        chk("rst_a", bus.douta, 32'd0);
        chk("rst_b", {20'd0, bus.doutb}, 32'd0);
        chk("rst_c", bus.doutc, 32'd0);
`ifdef DEMUX1TO3_STATS_EN
        chk("rst_cnt_a", {24'd0, cnt_a}, 32'd0);
        chk("rst_err_sel00", {31'd0, err_sel00}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].din, vecs[i].s, vecs[i].v, vecs[i].ra, vecs[i].rb, vecs[i].rc);
            #1;
            chk($sformatf("v%0d_din_ready", i), {31'd0, bus.din_ready}, {31'd0, vecs[i].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_va", i), {31'd0, bus.douta_valid}, {31'd0, vecs[i].va});
            chk($sformatf("v%0d_a", i), bus.douta, vecs[i].a);
            chk($sformatf("v%0d_vb", i), {31'd0, bus.doutb_valid}, {31'd0, vecs[i].vb});
            chk($sformatf("v%0d_b", i), {20'd0, bus.doutb}, {20'd0, vecs[i].b});
            chk($sformatf("v%0d_vc", i), {31'd0, bus.doutc_valid}, {31'd0, vecs[i].vc});
            chk($sformatf("v%0d_c", i), bus.doutc, vecs[i].c);
        end
`ifdef DEMUX1TO3_STATS_EN
        chk("tbl_cnt_a", {24'd0, cnt_a}, 32'd2);
        chk("tbl_cnt_b", {24'd0, cnt_b}, 32'd2);
        chk("tbl_cnt_c", {24'd0, cnt_c}, 32'd2);
        chk("tbl_err_sel00", {31'd0, err_sel00}, 32'd1);
`endif

        // Asynchronous reset mid-run with channel A full
        @(negedge clk);
        drive(32'h00000077, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(32'h0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_va", {31'd0, bus.douta_valid}, 32'd1);
        chk("pre_rst_a", bus.douta, 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_va", {31'd0, bus.douta_valid}, 32'd0);
        chk("async_rst_a", bus.douta, 32'd0);
        chk("async_rst_vb", {31'd0, bus.doutb_valid}, 32'd0);
        chk("async_rst_din_ready", {31'd0, bus.din_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int sv = 0; sv < 4; sv++) begin
            bus.s = sv[1:0];
            #1;
            chk($sformatf("idle_ready_s%0d", sv), {31'd0, bus.din_ready}, 32'd1);
        end

        // 300 back-to-back words into A with the consumer always ready
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(32'h1000 + i, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            chk($sformatf("stream%0d_ready", i), {31'd0, bus.din_ready}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d_va", i), {31'd0, bus.douta_valid}, 32'd1);
            chk($sformatf("stream%0d_a", i), bus.douta, 32'h1000 + i);
        end
        @(negedge clk);
        drive(32'h0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("stream_drained_va", {31'd0, bus.douta_valid}, 32'd0);
`ifdef DEMUX1TO3_STATS_EN
        chk("stream_cnt_a", {24'd0, cnt_a}, 32'd44);
        chk("stream_err_sel00", {31'd0, err_sel00}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
